kodirovka: RTL and testbench
============================

KODIROVKA -- requirements
Module: kodirovka

Interface
REQ-001 Parameter STROBE_LEN, default 2, SHALL set the number of clk cycles peredacha is held high per byte (legal range 1..15).
REQ-002 Parameter GAP, default 25, SHALL set the number of clk cycles peredacha is held low after each byte's strobe (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 char_in  input  8  SHALL carry a plain character byte, sampled only when char_valid=1.
REQ-006 char_valid  input  1  SHALL request transmission of char_in as a one-byte sequence.
REQ-007 left_cursor, right_cursor, Delete, Enter  input  1 each  SHALL each request transmission of that key's byte sequence.
REQ-008 out  output  8  SHALL carry the byte currently being transmitted.
REQ-009 peredacha  output  1  SHALL be the byte strobe; out is valid and stable whenever peredacha=1.
REQ-010 busy  output  1  SHALL be high while a sequence is in progress.
REQ-011 lost  output  1  SHALL pulse high for one cycle when a request is dropped.

Function
REQ-012 Sequences SHALL be: left_cursor = 1B 5B 44; right_cursor = 1B 5B 43; Delete = 1B 5B 33 7E; Enter = 0D; char_valid = char_in (1 byte, any value, including 1B).
REQ-013 The FSM SHALL have states IDLE, STROBE and GAP; the reset state is IDLE.
REQ-014 In IDLE, any request sampled high at edge N SHALL be accepted at N; at N+1, out = first byte, peredacha=1, busy=1, state=STROBE.
REQ-015 Simultaneous requests in IDLE SHALL be resolved by fixed priority Delete > Enter > left_cursor > right_cursor > char_valid; the losing requests SHALL be dropped, with lost=1 at N+1.
REQ-016 STROBE SHALL last exactly STROBE_LEN cycles with out constant, then go to GAP with peredacha=0.
REQ-017 GAP SHALL last exactly GAP cycles. If bytes remain, the state SHALL return to STROBE with the next byte loaded on the same edge; otherwise the state SHALL return to IDLE with busy=0.
REQ-018 out SHALL hold the last transmitted byte through GAP and IDLE until the next byte loads.
REQ-019 Byte-to-byte strobe period SHALL be STROBE_LEN+GAP cycles.
REQ-020 Total busy time SHALL be L*(STROBE_LEN+GAP) cycles, where L is the sequence length.
REQ-021 Any request sampled high while busy=1 SHALL be ignored and SHALL produce lost=1 on the next cycle (one pulse per sampled cycle); the current sequence SHALL be unaffected.
REQ-022 A request present on the same edge that the FSM enters IDLE SHALL be accepted only on the following edge; requests are level-sampled, so a request held high across the end of busy SHALL start a new sequence.
REQ-023 The byte index counter SHALL be 2 bits and SHALL never wrap within a sequence; sequence length SHALL be latched at accept.
REQ-024 char_in SHALL be latched at accept; later changes SHALL NOT affect out.

Reset
REQ-025 Reset_n=0 SHALL immediately, with no clock, force out=00, peredacha=0, busy=0, lost=0, state=IDLE, all counters to 0.
REQ-026 Reset_n asserted mid-sequence SHALL abort the sequence; after release, no remaining bytes SHALL be sent.
REQ-027 The first request SHALL be sampled on the first rising edge after Reset_n deasserts.

Verification (defaults STROBE_LEN=2, GAP=25)
REQ-028 Delete pulse in IDLE -> out 1B,5B,33,7E, each with a 2-cycle peredacha; strobe rises every 27 cycles; busy high for 108 cycles; then out=7E and busy=0.
REQ-029 left_cursor and char_valid (char_in=41) high on the same cycle -> sequence 1B 5B 44 is sent; lost=1 for one cycle; 41 is never sent.
REQ-030 Enter, then right_cursor pulsed 10 cycles later -> single byte 0D; one lost pulse; busy for 27 cycles; no 1B sent.
REQ-031 char_valid with char_in=FF, char_in changed to 00 one cycle later -> out=FF for the full strobe; busy for 27 cycles.
REQ-032 Reset_n low during the GAP after byte 5B of a right_cursor sequence -> immediately out=00, busy=0; after release, no 43 is sent.
REQ-033 right_cursor held high for 200 cycles -> back-to-back 1B 5B 43 sequences, each separated by exactly 1 IDLE cycle.

Source files
------------

// File: rtl/kodirovka.sv
// Key-to-byte-sequence encoder: each accepted key request is sent as a short
// byte sequence. Every byte is strobed on peredacha and followed by a quiet gap.
module kodirovka #(
    parameter int STROBE_LEN = 2,
    parameter int GAP        = 25
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    input  logic       left_cursor,
    input  logic       right_cursor,
    input  logic       Delete,
    input  logic       Enter,
    output logic [7:0] out,
    output logic       peredacha,
    output logic       busy,
    output logic       lost
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    localparam logic [2:0] K_DEL   = 3'd0;
    localparam logic [2:0] K_ENTER = 3'd1;
    localparam logic [2:0] K_LEFT  = 3'd2;
    localparam logic [2:0] K_RIGHT = 3'd3;
    localparam logic [2:0] K_CHAR  = 3'd4;

    localparam logic [7:0] STROBE_LAST = 8'(STROBE_LEN - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP - 1);

    function automatic logic [7:0] seq_byte(input logic [2:0] key, input logic [1:0] idx,
                                            input logic [7:0] ch);
        logic [7:0] b;
        b = 8'h00;
        case (key)
            K_DEL: begin
                case (idx)
                    2'd0:    b = 8'h1B;
                    2'd1:    b = 8'h5B;
                    2'd2:    b = 8'h33;
                    default: b = 8'h7E;
                endcase
            end
            K_ENTER: b = 8'h0D;
            K_LEFT: begin
                case (idx)
                    2'd0:    b = 8'h1B;
                    2'd1:    b = 8'h5B;
                    default: b = 8'h44;
                endcase
            end
            K_RIGHT: begin
                case (idx)
                    2'd0:    b = 8'h1B;
                    2'd1:    b = 8'h5B;
                    default: b = 8'h43;
                endcase
            end
            K_CHAR:  b = ch;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Index of the final byte, so the 2-bit index stops before it could wrap.
    function automatic logic [1:0] seq_last(input logic [2:0] key);
        logic [1:0] l;
        case (key)
            K_DEL:   l = 2'd3;
            K_LEFT:  l = 2'd2;
            K_RIGHT: l = 2'd2;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    logic [2:0] key_q, key_d;
    logic [7:0] char_q, char_d;
    logic [7:0] out_q, out_d;
    logic       per_q, per_d;
    logic       busy_q, busy_d;
    logic       lost_q, lost_d;

    logic [4:0] req_s;
    logic       any_req_s;
    logic       multi_req_s;
    logic [2:0] win_key_s;
    logic       load_s;

    // Request decode and fixed-priority arbitration.
    always_comb begin
        req_s       = {Delete, Enter, left_cursor, right_cursor, char_valid};
        any_req_s   = |req_s;
        multi_req_s = (req_s & (req_s - 5'd1)) != 5'd0;
        if (Delete)            win_key_s = K_DEL;
        else if (Enter)        win_key_s = K_ENTER;
        else if (left_cursor)  win_key_s = K_LEFT;
        else if (right_cursor) win_key_s = K_RIGHT;
        else                   win_key_s = K_CHAR;
    end

    // Next-state logic: strobe/gap timing and byte sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        key_d   = key_q;
        char_d  = char_q;
        load_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    state_d = S_STROBE;
                    cnt_d   = 8'd0;
                    idx_d   = 2'd0;
                    key_d   = win_key_s;
                    last_d  = seq_last(win_key_s);
                    char_d  = char_in;
                    load_s  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q == last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STROBE;
                        idx_d   = idx_q + 2'd1;
                        load_s  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: values the output registers take on the next edge.
    always_comb begin
        if (load_s) out_d = seq_byte(key_d, idx_d, char_d);
        else        out_d = out_q;
        per_d  = (state_d == S_STROBE);
        busy_d = (state_d != S_IDLE);
        if (state_q == S_IDLE) lost_d = multi_req_s;
        else                   lost_d = any_req_s;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            key_q   <= 3'd0;
            char_q  <= 8'd0;
            out_q   <= 8'd0;
            per_q   <= 1'b0;
            busy_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            key_q   <= key_d;
            char_q  <= char_d;
            out_q   <= out_d;
            per_q   <= per_d;
            busy_q  <= busy_d;
            lost_q  <= lost_d;
        end
    end

    assign out       = out_q;
    assign peredacha = per_q;
    assign busy      = busy_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_kodirovka.sv
// Bench for kodirovka: a transaction-level model (elapsed time since accept,
// byte = seq[elapsed / period]) is compared every cycle, plus literal scenario checks.
module tb_kodirovka;
    localparam int S = 2;
    localparam int G = 25;
    localparam int P = S + G;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       left_cursor = 1'b0;
    logic       right_cursor = 1'b0;
    logic       Delete = 1'b0;
    logic       Enter = 1'b0;
    logic [7:0] out;
    logic       peredacha;
    logic       busy;
    logic       lost;

    kodirovka #(.STROBE_LEN(S), .GAP(G)) dut (
        .clk(clk), .Reset_n(Reset_n), .char_in(char_in), .char_valid(char_valid),
        .left_cursor(left_cursor), .right_cursor(right_cursor), .Delete(Delete),
        .Enter(Enter), .out(out), .peredacha(peredacha), .busy(busy), .lost(lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state
    bit         m_act = 1'b0;
    int         m_el = 0;
    int         m_len = 0;
    logic [7:0] m_out = 8'h00;
    bit         m_lost = 1'b0;
    logic [7:0] m_seq [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    initial forever begin
        int nreq;
        @(posedge clk or negedge Reset_n);
        if (!Reset_n) begin
            m_act = 1'b0; m_el = 0; m_out = 8'h00; m_lost = 1'b0;
        end else begin
            nreq = int'(Delete) + int'(Enter) + int'(left_cursor) + int'(right_cursor)
                 + int'(char_valid);
            if (m_act) begin
                m_lost = (nreq > 0);
                m_el++;
                if (m_el == m_len * P) m_act = 1'b0;
            end else begin
                m_lost = (nreq > 1);
                if (nreq > 0) begin
                    if (Delete) begin
                        m_seq = '{8'h1B, 8'h5B, 8'h33, 8'h7E}; m_len = 4;
                    end else if (Enter) begin
                        m_seq[0] = 8'h0D; m_len = 1;
                    end else if (left_cursor) begin
                        m_seq = '{8'h1B, 8'h5B, 8'h44, 8'h00}; m_len = 3;
                    end else if (right_cursor) begin
                        m_seq = '{8'h1B, 8'h5B, 8'h43, 8'h00}; m_len = 3;
                    end else begin
                        m_seq[0] = char_in; m_len = 1;
                    end
                    m_act = 1'b1;
                    m_el = 0;
                end
            end
            if (m_act) m_out = m_seq[m_el / P];
        end
    end

    // Observation log
    logic [7:0] obs[$];
    int         stamps[$];
    logic [7:0] exp_q[$];
    int         busy_cnt = 0;
    int         lost_cnt = 0;
    int         cyc = 0;
    bit         prev_per = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (Reset_n) begin
            check("out", int'(out), int'(m_out));
            check("peredacha", int'(peredacha), int'(m_act && ((m_el % P) < S)));
            check("busy", int'(busy), int'(m_act));
            check("lost", int'(lost), int'(m_lost));
            if (peredacha && !prev_per) begin
                obs.push_back(out);
                stamps.push_back(cyc);
            end
            busy_cnt += int'(busy);
            lost_cnt += int'(lost);
        end
        prev_per = peredacha;
    end

    task automatic clear_log();
        obs.delete();
        stamps.delete();
        busy_cnt = 0;
        lost_cnt = 0;
    endtask

    task automatic check_bytes(input string name);
        check({name, "_nbytes"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs.size()) check({name, "_byte"}, int'(obs[i]), int'(exp_q[i]));
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        wait_neg(3);
        check("reset_out", int'(out), 0);
        check("reset_peredacha", int'(peredacha), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_lost", int'(lost), 0);
        Reset_n = 1'b1;
        wait_neg(2);
        clear_log();

        // Delete pulse
        Delete = 1'b1; wait_neg(1); Delete = 1'b0;
        wait_neg(120);
        exp_q = '{8'h1B, 8'h5B, 8'h33, 8'h7E};
        check_bytes("delete");
        check("delete_busy_cycles", busy_cnt, 108);
        check("delete_lost", lost_cnt, 0);
        for (int i = 1; i < stamps.size(); i++)
            check("delete_period", stamps[i] - stamps[i-1], 27);
        check("delete_out_after", int'(out), 8'h7E);
        check("delete_busy_after", int'(busy), 0);
        clear_log();

        // left_cursor and char_valid together
        left_cursor = 1'b1; char_valid = 1'b1; char_in = 8'h41;
        wait_neg(1); left_cursor = 1'b0; char_valid = 1'b0;
        wait_neg(90);
        exp_q = '{8'h1B, 8'h5B, 8'h44};
        check_bytes("left_char");
        check("left_char_busy_cycles", busy_cnt, 81);
        check("left_char_lost", lost_cnt, 1);
        clear_log();

        // Enter, then right_cursor 10 cycles later
        Enter = 1'b1; wait_neg(1); Enter = 1'b0;
        wait_neg(9);
        right_cursor = 1'b1; wait_neg(1); right_cursor = 1'b0;
        wait_neg(30);
        exp_q = '{8'h0D};
        check_bytes("enter_right");
        check("enter_right_busy_cycles", busy_cnt, 27);
        check("enter_right_lost", lost_cnt, 1);
        clear_log();

        // char FF, changed right after accept
        char_in = 8'hFF; char_valid = 1'b1; wait_neg(1);
        char_valid = 1'b0; char_in = 8'h00;
        wait_neg(30);
        exp_q = '{8'hFF};
        check_bytes("char_ff");
        check("char_ff_busy_cycles", busy_cnt, 27);
        check("char_ff_lost", lost_cnt, 0);
        clear_log();

        // Reset during the gap after 5B of a right_cursor sequence
        right_cursor = 1'b1; wait_neg(1); right_cursor = 1'b0;
        wait_neg(40);
        @(posedge clk); #2;
        Reset_n = 1'b0;
        #1;
        check("midreset_out", int'(out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_peredacha", int'(peredacha), 0);
        @(negedge clk); Reset_n = 1'b1;
        wait_neg(100);
        exp_q = '{8'h1B, 8'h5B};
        check_bytes("midreset");
        check("midreset_busy_after", int'(busy), 0);
        clear_log();

        // right_cursor held for 200 cycles
        right_cursor = 1'b1; wait_neg(200); right_cursor = 1'b0;
        wait_neg(100);
        exp_q = '{8'h1B, 8'h5B, 8'h43, 8'h1B, 8'h5B, 8'h43, 8'h1B, 8'h5B, 8'h43};
        check_bytes("held");
        check("held_busy_cycles", busy_cnt, 243);
        check("held_lost", lost_cnt, 197);
        for (int i = 1; i < stamps.size(); i++)
            check("held_period", stamps[i] - stamps[i-1], (i % 3 == 0) ? 28 : 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
